// File: rtl/mash_noise_cancel_if.sv
// mash_noise_cancel_if
// Bundles the sample inputs and result outputs of mash_noise_cancel.
//   master : driven by the modulator side (sample in, result out)
//   slave  : the canceller itself
// Handshake: valid-only streaming. A sample is accepted on the rising clock
// edge where i_valid=1 and i_clear=0. There is no ready; the canceller takes
// one sample every cycle. o_valid pulses for one cycle, one clock after each
// accepted sample. o_avg_valid pulses in that same cycle when the sample
// completes an averaging window.
interface mash_noise_cancel_if #(
  parameter int P_INT_WIDTH = 8,
  parameter int P_AVG_LOG2  = 8
);
  logic                          i_valid;
  logic [1:0]                    i_order;
  logic                          i_q1;
  logic                          i_q2;
  logic                          i_q3;
  logic [P_INT_WIDTH-1:0]        i_n_int;
  logic                          i_clear;
  logic [P_INT_WIDTH-1:0]        o_div;
  logic                          o_valid;
  logic                          o_sat;
  logic signed [P_AVG_LOG2+2:0]  o_avg;
  logic                          o_avg_valid;

  modport master (
    output i_valid, i_order, i_q1, i_q2, i_q3, i_n_int, i_clear,
    input  o_div, o_valid, o_sat, o_avg, o_avg_valid
  );

  modport slave (
    input  i_valid, i_order, i_q1, i_q2, i_q3, i_n_int, i_clear,
    output o_div, o_valid, o_sat, o_avg, o_avg_valid
  );
endinterface

// File: rtl/mash_noise_cancel.sv
// mash_noise_cancel
// Recombines the three carry streams of a MASH 1-1-1 modulator into one
// signed correction y, adds it to the integer divide value to form a
// saturated divider modulus, and sums y over a 2^P_AVG_LOG2-sample window
// so the effective fraction can be read back.
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous active-high reset
//   bus    : mash_noise_cancel_if.slave (samples in, modulus/average out)
module mash_noise_cancel #(
  parameter int P_INT_WIDTH = 8,
  parameter int P_AVG_LOG2  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mash_noise_cancel_if.slave   bus
);

  localparam int SW = P_INT_WIDTH + 2;  // signed sum width
  localparam int AW = P_AVG_LOG2 + 3;   // accumulator width

  // Carry history: c2 delayed once, c3 delayed once and twice.
  logic c2d, c3d1, c3d2;

  logic signed [AW-1:0]   acc;
  logic [P_AVG_LOG2-1:0]  cnt;

  logic                   accept;
  logic signed [3:0]      y;
  logic signed [SW-1:0]   sum;
  logic [P_INT_WIDTH-1:0] div_next;
  logic                   sat_next;
  logic signed [AW-1:0]   y_ext;
  logic signed [AW-1:0]   acc_sum;
  logic                   window_end;

  // A sample coinciding with clear is discarded.
  assign accept = bus.i_valid & ~bus.i_clear;

  // Correction: each order adds the next difference term; order 0 acts as 1.
  always_comb begin
    y = {3'b000, bus.i_q1};
    if (bus.i_order == 2'd2 || bus.i_order == 2'd3) begin
      y = y + $signed({3'b000, bus.i_q2}) - $signed({3'b000, c2d});
    end
    if (bus.i_order == 2'd3) begin
      y = y + $signed({3'b000, bus.i_q3}) - $signed({2'b00, c3d1, 1'b0})
            + $signed({3'b000, c3d2});
    end
  end

  // Modulus with clamping to the unsigned output range.
  always_comb begin
    sum      = $signed({2'b00, bus.i_n_int}) + $signed({{(SW-4){y[3]}}, y});
    div_next = sum[P_INT_WIDTH-1:0];
    sat_next = 1'b0;
    if (sum[SW-1]) begin
      div_next = '0;
      sat_next = 1'b1;
    end else if (sum[SW-2]) begin
      div_next = '1;
      sat_next = 1'b1;
    end
  end

  assign y_ext      = {{(AW-4){y[3]}}, y};
  assign acc_sum    = acc + y_ext;
  assign window_end = (cnt == {P_AVG_LOG2{1'b1}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      c2d             <= 1'b0;
      c3d1            <= 1'b0;
      c3d2            <= 1'b0;
      acc             <= '0;
      cnt             <= '0;
      bus.o_div       <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_sat       <= 1'b0;
      bus.o_avg       <= '0;
      bus.o_avg_valid <= 1'b0;
    end else if (bus.i_clear) begin
      // Outputs o_div, o_sat and o_avg deliberately hold across a clear.
      c2d             <= 1'b0;
      c3d1            <= 1'b0;
      c3d2            <= 1'b0;
      acc             <= '0;
      cnt             <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_avg_valid <= 1'b0;
    end else begin
      bus.o_valid     <= accept;
      bus.o_avg_valid <= 1'b0;
      if (accept) begin
        c2d       <= bus.i_q2;
        c3d2      <= c3d1;
        c3d1      <= bus.i_q3;
        bus.o_div <= div_next;
        bus.o_sat <= sat_next;
        if (window_end) begin
          bus.o_avg       <= acc_sum;
          bus.o_avg_valid <= 1'b1;
          acc             <= '0;
          cnt             <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mash_noise_cancel.sv
module tb_mash_noise_cancel;

  localparam int W = 8;
  localparam int L = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pulses;
  logic [W-1:0] exp_q[$];

  mash_noise_cancel_if #(.P_INT_WIDTH(W), .P_AVG_LOG2(L)) bus ();

  mash_noise_cancel #(.P_INT_WIDTH(W), .P_AVG_LOG2(L)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one cycle of inputs, then return 1 ns after the capturing edge.
  task automatic send(input logic v, input logic [1:0] ord, input logic a,
                      input logic b, input logic c, input logic [W-1:0] n);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_order = ord;
    bus.i_q1    = a;
    bus.i_q2    = b;
    bus.i_q3    = c;
    bus.i_n_int = n;
    bus.i_clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Clear with a valid sample presented alongside; that sample must be dropped.
  task automatic do_clear();
    @(negedge clk);
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_q1    = 1'b1;
    bus.i_q2    = 1'b1;
    bus.i_q3    = 1'b1;
    @(posedge clk);
    #1;
    check("clear_valid", 32'(bus.o_valid), 0);
    check("clear_avg_valid", 32'(bus.o_avg_valid), 0);
  endtask

  // Push expected modulus then pop it against the observed output.
  task automatic expect_div(input string tag, input logic [W-1:0] d, input logic s);
    exp_q.push_back(d);
    check({tag, "_valid"}, 32'(bus.o_valid), 1);
    check({tag, "_div"}, 32'(bus.o_div), 32'(exp_q.pop_front()));
    check({tag, "_sat"}, 32'(bus.o_sat), 32'(s));
  endtask

  // 256-sample window, c1 on every 4th sample; counts o_avg_valid pulses.
  task automatic run_window(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      send(1'b1, 2'd1, (i % 4) == 0, 1'b0, 1'b0, 8'd20);
      if (bus.o_avg_valid) begin
        pulses++;
        if (i != 255) check({tag, "_early_pulse"}, 32'(i), 255);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    bus.i_valid = 1'b0;
    bus.i_order = 2'd1;
    bus.i_q1    = 1'b0;
    bus.i_q2    = 1'b0;
    bus.i_q3    = 1'b0;
    bus.i_n_int = '0;
    bus.i_clear = 1'b0;

    // 1. reset with toggling inputs
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_valid = 1'($urandom_range(0, 1));
      bus.i_order = 2'($urandom_range(0, 3));
      bus.i_q1    = 1'($urandom_range(0, 1));
      bus.i_q2    = 1'($urandom_range(0, 1));
      bus.i_q3    = 1'($urandom_range(0, 1));
      bus.i_n_int = 8'($urandom_range(0, 255));
      bus.i_clear = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_div", 32'(bus.o_div), 0);
      check("rst_valid", 32'(bus.o_valid), 0);
      check("rst_sat", 32'(bus.o_sat), 0);
      check("rst_avg", 32'(bus.o_avg), 0);
      check("rst_avg_valid", 32'(bus.o_avg_valid), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.i_valid = 1'b0;

    // 2. order 1, n=20, c1 = 1,0,1; order 0 on the middle sample acts as 1
    send(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd20); expect_div("o1_s0", 8'd21, 1'b0);
    send(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd20); expect_div("o1_s1", 8'd20, 1'b0);
    send(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'd20); expect_div("o1_s2", 8'd21, 1'b0);
    send(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd20);
    check("o1_idle_valid", 32'(bus.o_valid), 0);
    check("o1_idle_hold", 32'(bus.o_div), 21);

    // 3. order 3, n=10, c3 impulse -> 11, 8, 11, 10
    do_clear();
    send(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'd10); expect_div("o3_s0", 8'd11, 1'b0);
    send(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd10); expect_div("o3_s1", 8'd8, 1'b0);
    send(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd10); expect_div("o3_s2", 8'd11, 1'b0);
    send(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd10); expect_div("o3_s3", 8'd10, 1'b0);

    // 4. order 2 with a two-cycle gap -> 11, (hold), 10, 10
    do_clear();
    send(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'd10); expect_div("o2_s0", 8'd11, 1'b0);
    for (int g = 0; g < 2; g++) begin
      send(1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd10);
      check("o2_gap_valid", 32'(bus.o_valid), 0);
      check("o2_gap_hold", 32'(bus.o_div), 11);
    end
    send(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'd10); expect_div("o2_s1", 8'd10, 1'b0);
    send(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'd10); expect_div("o2_s2", 8'd10, 1'b0);

    // 5. saturation; prime history c3d1=0, c3d2=1, c2d=0 in order 1
    do_clear();
    send(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd20); expect_div("sat_p0", 8'd20, 1'b0);
    send(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd20); expect_div("sat_p1", 8'd20, 1'b0);
    // y = 1+1-0+1-0+1 = 4, 254+4 -> clamp 255
    send(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 8'd254); expect_div("sat_hi", 8'd255, 1'b1);
    // history now c2d=1, c3d1=1, c3d2=0: y = -1-2 = -3, 1-3 -> clamp 0
    send(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd1); expect_div("sat_lo", 8'd0, 1'b1);
    // history c2d=0, c3d1=0, c3d2=1: y = 1, no clamp
    send(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd100); expect_div("sat_none", 8'd101, 1'b0);

    // 6. averager: one pulse with o_avg = 64
    do_clear();
    pulses = 0;
    run_window(256, "avg1");
    check("avg1_pulse_cnt", 32'(pulses), 1);
    check("avg1_value", 32'($signed(bus.o_avg)), 64);
    send(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd20);
    check("avg1_pulse_width", 32'(bus.o_avg_valid), 0);

    // clear at sample 100, then a full window is needed for the next pulse
    pulses = 0;
    run_window(100, "avg2a");
    do_clear();
    check("avg2_hold_clear", 32'($signed(bus.o_avg)), 64);
    run_window(255, "avg2b");
    check("avg2_no_pulse", 32'(pulses), 0);
    check("avg2_hold", 32'($signed(bus.o_avg)), 64);
    send(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd20);
    check("avg2_pulse", 32'(bus.o_avg_valid), 1);
    check("avg2_value", 32'($signed(bus.o_avg)), 64);

    // reset mid-window: o_avg goes back to 0 asynchronously
    run_window(10, "avg3");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_avg", 32'($signed(bus.o_avg)), 0);
    check("rst_mid_div", 32'(bus.o_div), 0);
    @(negedge clk);
    rst = 1'b0;
    send(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd7); expect_div("post_rst", 8'd8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mash_noise_cancel.md
Name: mash_noise_cancel

Overview:
- Recombines the three 1-bit carry streams of the 3-stage EFM/MASH modulator into one signed multi-bit correction.
- Adds that correction to the integer divide value to form the per-cycle divider modulus for the fractional-N divider.
- Also accumulates the correction over a fixed window so the effective fraction can be read back and checked against the programmed level.

Parameters:
- P_INT_WIDTH, 8, width of integer divide value and of output modulus (unsigned).
- P_AVG_LOG2, 8, log2 of averaging window length in accepted samples.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  qualifies i_q1..i_q3 and i_n_int this cycle.
- i_order  input  2  cancellation order: 1 = MASH-1, 2 = MASH-1-1, 3 = MASH-1-1-1; 0 is treated as 1.
- i_q1  input  1  first-stage carry c1.
- i_q2  input  1  second-stage carry c2.
- i_q3  input  1  third-stage carry c3.
- i_n_int  input  P_INT_WIDTH  integer divide value (unsigned).
- i_clear  input  1  synchronous clear of history and averager.
- o_div  output  P_INT_WIDTH  registered modulus i_n_int + y, saturated.
- o_valid  output  1  o_div valid strobe.
- o_sat  output  1  set with o_valid when o_div was clamped.
- o_avg  output  P_AVG_LOG2+3  signed sum of y over the last completed window.
- o_avg_valid  output  1  one-cycle pulse when o_avg updates.

Behaviour:
- Reset (async, i_rst=1): all of these are 0: o_div, o_valid, o_sat, o_avg, o_avg_valid, history registers c2d, c3d1, c3d2, accumulator, sample counter.
- History update: on each cycle with i_valid=1, c2d<=i_q2, c3d2<=c3d1, c3d1<=i_q3. With i_valid=0, history holds. History updates in every order mode.
- Correction y, combinational, 4-bit signed:
  - order 1 (or 0): y = c1, range 0..1.
  - order 2: y = c1 + c2 - c2d, range -1..2.
  - order 3: y = c1 + c2 - c2d + c3 - 2*c3d1 + c3d2, range -3..4.
- Sum: computed at P_INT_WIDTH+2 signed bits.
  - Sum < 0: clamp to 0, o_sat=1.
  - Sum > 2^P_INT_WIDTH-1: clamp to max, o_sat=1.
- Latency: 1 cycle.
  - o_valid <= i_valid.
  - o_div and o_sat are registered only when i_valid=1; otherwise they hold their last value, and o_valid=0.
- i_order may change at any time. The new order applies to the next accepted sample, and history is not cleared.
- Averager:
  - acc accumulates y (unsaturated) on each accepted sample; cnt counts accepted samples modulo 2^P_AVG_LOG2.
  - On the accepted sample with cnt = 2^P_AVG_LOG2-1:
    - o_avg <= acc + y.
    - o_avg_valid=1 in the same cycle as o_valid for that sample.
    - acc <= 0 and cnt <= 0.
  - o_avg holds between windows.
- i_clear=1:
  - Next edge: history, acc and cnt go to 0; o_valid=0 and o_avg_valid=0.
  - o_div, o_sat and o_avg hold.
  - A sample presented with i_valid in the same cycle is discarded.
- Simultaneous i_clear and window end: clear wins, and no o_avg_valid pulse is produced.
- Reset mid-window: the partial window is lost and o_avg returns to 0.

Test Plan:
1. Reset: assert i_rst with random inputs toggling -> o_div=0, o_valid=0, o_sat=0, o_avg=0, o_avg_valid=0 while asserted; first valid sample after release appears one cycle later.
2. Order 1, n_int=20, c1 = 1,0,1 on consecutive valid cycles -> o_div = 21,20,21, each one cycle after its input, o_valid high for 3 cycles.
3. Order 3, n_int=10, c1=c2=0, c3 impulse 1,0,0,0 -> o_div = 11,8,11,10; o_sat=0 throughout.
4. Order 2 gaps: n_int=10, c2 = 1,1,1 with i_valid low for 2 cycles between the 1st and 2nd sample -> o_div = 11,10,10; o_valid low during the gap, o_div held at 11.
5. Saturation:
   - Part A: P_INT_WIDTH=8, order 3, n_int=254, history c3d1=0, c3d2=1, c2d=0, inputs c1=c2=c3=1 -> y=4, o_div=255, o_sat=1.
   - Part B: n_int=1, y=-3 (c1=c2=c3=0, c2d=1, c3d1=1, c3d2=0) -> o_div=0, o_sat=1.
6. Averager: P_AVG_LOG2=8, order 1, c1=1 on every 4th valid sample for 256 samples -> single o_avg_valid pulse with o_avg=64.
   - Repeat with i_clear at sample 100 -> no pulse until 256 samples after the clear, and o_avg holds 64.
